// File: rtl/fetch_buffer_if.sv
// Handshake and window bundle between the fetch port, the fetch buffer and the decode front end.
interface fetch_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            line_valid;
  logic            line_ready;
  logic [127:0]    line_data;
  logic [XLEN-1:0] line_pc;
  logic            win_valid;
  logic [127:0]    win_data;
  logic [XLEN-1:0] win_pc;
  logic [4:0]      win_advance;
  logic            flush;
  logic [3:0]      flush_offset;
  logic            err;

  modport master (
    output line_valid, line_data, line_pc, win_advance, flush, flush_offset,
    input  line_ready, win_valid, win_data, win_pc, err
  );

  modport slave (
    input  line_valid, line_data, line_pc, win_advance, flush, flush_offset,
    output line_ready, win_valid, win_data, win_pc, err
  );
endinterface

// File: rtl/fetch_buffer.sv
// Elastic ring of 16-byte fetch lines presenting a 16-byte decode window at any even offset.
module fetch_buffer #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned XLEN  = 32
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_buffer_if.slave fb_io
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t Full = cnt_t'(DEPTH);

  logic [127:0]    data_q [DEPTH];
  logic [XLEN-5:0] pc_q   [DEPTH];

  ptr_t       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic [3:0] off_q, off_d;
  logic       err_q, err_d;

  logic         line_ready, win_valid, push, pop, adv_bad;
  logic [4:0]   adv_clamp, adv_eff, sum;
  logic [255:0] pair, shifted;
  logic         unused_pc_lsb;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign line_ready = (count_q < Full);
  assign win_valid  = (count_q >= cnt_t'(2)) | ((count_q == cnt_t'(1)) & (off_q == 4'd0));

  // Head line in the low half; shifting the pair right by off bytes yields the window.
  assign pair    = {data_q[ptr_inc(rd_ptr_q)], data_q[rd_ptr_q]};
  assign shifted = pair >> {off_q, 3'b000};

  assign fb_io.line_ready = line_ready;
  assign fb_io.win_valid  = win_valid;
  assign fb_io.win_data   = win_valid ? shifted[127:0] : '0;
  assign fb_io.win_pc     = win_valid ? {pc_q[rd_ptr_q], off_q} : '0;
  assign fb_io.err        = err_q;

  assign unused_pc_lsb = ^fb_io.line_pc[3:0];

  // Illegal advances still update state: clamp to 16 and drop bit 0.
  assign adv_clamp = (fb_io.win_advance > 5'd16) ? 5'd16 : fb_io.win_advance;
  assign adv_eff   = {adv_clamp[4:1], 1'b0};
  assign sum       = {1'b0, off_q} + adv_eff;
  assign adv_bad   = win_valid & (fb_io.win_advance[0] | (fb_io.win_advance > 5'd16));

  assign push = fb_io.line_valid & line_ready & ~fb_io.flush;
  assign pop  = win_valid & ~fb_io.flush & sum[4];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    off_d    = off_q;
    err_d    = err_q | adv_bad | (fb_io.flush & fb_io.flush_offset[0]);
    if (fb_io.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      off_d    = {fb_io.flush_offset[3:1], 1'b0};
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (win_valid) off_d = sum[3:0];
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      off_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      off_q    <= off_d;
      err_q    <= err_d;
    end
  end

  // Line storage needs no reset: count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= fb_io.line_data;
      pc_q[wr_ptr_q]   <= fb_io.line_pc[XLEN-1:4];
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed table, hand sequences and random traffic vs. a line-queue model.
module tb_fetch_buffer;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned XLEN  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_buffer_if #(.XLEN(XLEN)) fb ();

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .fb_io (fb)
  );

  typedef struct {
    logic         rst;
    logic         lv;
    logic [127:0] ld;
    logic [31:0]  lpc;
    logic [4:0]   adv;
    logic         fl;
    logic [3:0]   fo;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic        rdy;
    logic        val;
    logic [31:0] pc;
    logic        err;
  } rec_t;

  typedef struct {
    logic [127:0] d;
    logic [31:0]  pc;
  } line_t;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of buffered lines plus the byte offset into the head line.
  line_t m_q[$];
  int    m_off = 0;
  bit    m_err = 0;

  function automatic bit m_valid();
    return (m_q.size() >= 2) || (m_q.size() == 1 && m_off == 0);
  endfunction

  function automatic bit m_ready();
    return m_q.size() < DEPTH;
  endfunction

  function automatic logic [31:0] m_pc();
    return {m_q[0].pc[31:4], 4'b0000} + 32'(m_off);
  endfunction

  function automatic logic [127:0] m_data();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      int idx = m_off + k;
      r[8*k +: 8] = (idx < 16) ? m_q[0].d[8*idx +: 8] : m_q[1].d[8*(idx-16) +: 8];
    end
    return r;
  endfunction

  function automatic void m_step(vec_t v);
    bit valid = m_valid();
    bit ready = m_ready();
    int a;
    int s;
    if (v.rst) begin
      m_q.delete(); m_off = 0; m_err = 0;
      return;
    end
    if (v.fl && v.fo[0]) m_err = 1;
    if (valid && (v.adv[0] || v.adv > 16)) m_err = 1;
    if (v.fl) begin
      m_q.delete(); m_off = int'(v.fo) & 14;
      return;
    end
    if (valid) begin
      a = (v.adv > 16) ? 16 : int'(v.adv);
      a = a & ~1;
      s = m_off + a;
      if (s >= 16) begin
        void'(m_q.pop_front());
        m_off = s - 16;
      end else begin
        m_off = s;
      end
    end
    if (v.lv && ready) m_q.push_back('{d: v.ld, pc: v.lpc});
  endfunction

  function automatic logic [127:0] mkline(logic [31:0] pc);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = {pc[7:4], 4'(k)};
    return r;
  endfunction

  function automatic vec_t V(logic r, logic lv, logic [31:0] lpc, logic [4:0] adv,
                             logic fl, logic [3:0] fo);
    vec_t v;
    v.rst = r; v.lv = lv; v.lpc = lpc; v.ld = mkline(lpc);
    v.adv = adv; v.fl = fl; v.fo = fo;
    return v;
  endfunction

  function automatic rec_t R(vec_t v, logic rdy, logic val, logic [31:0] pc, logic err);
    rec_t r;
    r.v = v; r.rdy = rdy; r.val = val; r.pc = pc; r.err = err;
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic settle(vec_t v);
    rst               = v.rst;
    fb.line_valid     = v.lv;
    fb.line_data      = v.ld;
    fb.line_pc        = v.lpc;
    fb.win_advance    = v.adv;
    fb.flush          = v.fl;
    fb.flush_offset   = v.fo;
    @(negedge clk);
  endtask

  task automatic model_check();
    chk("ready", 128'(fb.line_ready), 128'(m_ready()));
    chk("valid", 128'(fb.win_valid), 128'(m_valid()));
    chk("err", 128'(fb.err), 128'(m_err));
    if (m_valid()) begin
      chk("win_data", fb.win_data, m_data());
      chk("win_pc", 128'(fb.win_pc), 128'(m_pc()));
    end
  endtask

  task automatic commit(vec_t v);
    m_step(v);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  rec_t tbl[$];
  vec_t idle;
  vec_t v;

  initial begin
    idle = V(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 4'd0);

    // Expected outputs are those observed in the cycle the inputs are applied.
    tbl.push_back(R(idle,                                  1, 0, 32'h0,     0));
    tbl.push_back(R(V(0, 1, B + 32'h00, 0, 0, 0),          1, 0, 32'h0,     0));
    tbl.push_back(R(V(0, 1, B + 32'h10, 0, 0, 0),          1, 1, B,         0));
    tbl.push_back(R(V(0, 0, 0, 6, 0, 0),                   1, 1, B,         0));
    tbl.push_back(R(V(0, 0, 0, 8, 0, 0),                   1, 1, B + 6,     0));
    tbl.push_back(R(V(0, 1, B + 32'h20, 4, 0, 0),          1, 1, B + 14,    0));
    tbl.push_back(R(V(0, 1, B + 32'h30, 0, 0, 0),          1, 1, B + 18,    0));
    tbl.push_back(R(V(0, 1, B + 32'h40, 0, 0, 0),          0, 1, B + 18,    0));
    tbl.push_back(R(V(0, 1, B + 32'h40, 16, 0, 0),         0, 1, B + 18,    0));
    tbl.push_back(R(V(0, 1, B + 32'h40, 0, 0, 0),          1, 1, B + 34,    0));
    tbl.push_back(R(idle,                                  0, 1, B + 34,    0));
    tbl.push_back(R(V(0, 1, B + 32'h50, 0, 1, 6),          0, 1, B + 34,    0));
    tbl.push_back(R(idle,                                  1, 0, 32'h0,     0));
    tbl.push_back(R(V(0, 1, B + 32'h100, 0, 0, 0),         1, 0, 32'h0,     0));
    tbl.push_back(R(V(0, 1, B + 32'h110, 0, 0, 0),         1, 0, 32'h0,     0));
    tbl.push_back(R(idle,                                  1, 1, B + 32'h106, 0));
    tbl.push_back(R(V(0, 0, 0, 5, 0, 0),                   1, 1, B + 32'h106, 0));
    tbl.push_back(R(idle,                                  1, 1, B + 32'h10A, 1));
    tbl.push_back(R(V(0, 0, 0, 18, 0, 0),                  1, 1, B + 32'h10A, 1));
    tbl.push_back(R(idle,                                  1, 0, 32'h0,     1));
    tbl.push_back(R(V(0, 1, B + 32'h120, 0, 0, 0),         1, 0, 32'h0,     1));
    tbl.push_back(R(idle,                                  1, 1, B + 32'h11A, 1));
    tbl.push_back(R(V(1, 1, B + 32'h130, 2, 1, 4),         1, 1, B + 32'h11A, 1));

    v = idle; v.rst = 1'b1;
    settle(v); commit(v);
    settle(v); commit(v);

    foreach (tbl[i]) begin
      settle(tbl[i].v);
      chk($sformatf("tbl%0d_ready", i), 128'(fb.line_ready), 128'(tbl[i].rdy));
      chk($sformatf("tbl%0d_valid", i), 128'(fb.win_valid), 128'(tbl[i].val));
      chk($sformatf("tbl%0d_err", i), 128'(fb.err), 128'(tbl[i].err));
      if (tbl[i].val) chk($sformatf("tbl%0d_pc", i), 128'(fb.win_pc), 128'(tbl[i].pc));
      model_check();
      if (i == 4) begin
        chk("shift_byte0", 128'(fb.win_data[7:0]), 128'(8'h06));
        chk("span_byte10", 128'(fb.win_data[87:80]), 128'(8'h10));
      end
      commit(tbl[i].v);
    end

    // Outputs after a reset that coincided with a flush and a push.
    settle(idle);
    chk("rst_ready", 128'(fb.line_ready), 128'(1));
    chk("rst_valid", 128'(fb.win_valid), 128'(0));
    chk("rst_err", 128'(fb.err), 128'(0));
    chk("rst_data", fb.win_data, 128'(0));
    chk("rst_pc", 128'(fb.win_pc), 128'(0));
    commit(idle);

    // Odd flush offset sets the sticky error.
    v = V(0, 0, 0, 0, 1, 3);
    settle(v); chk("oddfo_before", 128'(fb.err), 128'(0)); commit(v);
    settle(idle); chk("oddfo_after", 128'(fb.err), 128'(1)); model_check(); commit(idle);
    v = idle; v.rst = 1'b1;
    settle(v); commit(v);

    // Streaming: one line offered per cycle, full advance every cycle.
    for (int i = 0; i < 22; i++) begin
      v = (i < 20) ? V(0, 1, 32'h9000_0000 + 32'(16 * i), 16, 0, 0) : V(0, 0, 0, 16, 0, 0);
      settle(v);
      model_check();
      if (i >= 1 && i <= 20) begin
        chk($sformatf("stream%0d_valid", i), 128'(fb.win_valid), 128'(1));
        chk($sformatf("stream%0d_pc", i), 128'(fb.win_pc), 128'(32'h9000_0000 + 32'(16 * (i - 1))));
      end
      if (i < 20) chk($sformatf("stream%0d_ready", i), 128'(fb.line_ready), 128'(1));
      commit(v);
    end
    settle(idle);
    chk("stream_drained", 128'(fb.win_valid), 128'(0));
    commit(idle);

    // Random traffic against the model.
    begin
      logic [31:0] nxt_pc = 32'h4000_0000;
      for (int i = 0; i < 1500; i++) begin
        int r = int'($urandom_range(0, 99));
        v.rst = ($urandom_range(0, 399) == 0);
        v.fl  = ($urandom_range(0, 29) == 0);
        v.fo  = ($urandom_range(0, 99) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 7) * 2);
        v.lv  = ($urandom_range(0, 3) != 0);
        v.lpc = nxt_pc;
        v.ld  = {$urandom, $urandom, $urandom, $urandom};
        v.adv = (r < 3) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8) * 2);
        settle(v);
        model_check();
        if (v.fl && !v.rst) nxt_pc = {$urandom} & 32'hFFFF_FFF0;
        else if (v.lv && m_ready() && !v.rst) nxt_pc = nxt_pc + 32'd16;
        commit(v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
